// File: rtl/spc_pkg.sv
// spc shared types and sizing for the serial-to-parallel converter.
// Optional feature macro: SPC_VALID_EN (adds dout_valid on spc).
package spc_pkg;

  localparam int SPC_OUT_W = 2;

  function automatic int spc_phase_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int SPC_PHASE_W = spc_phase_w(SPC_OUT_W);

  typedef logic [SPC_OUT_W-1:0] spc_sym_t;

endpackage

// File: rtl/spc_phase_cnt.sv
// spc_phase_cnt: modulo-N bit-phase counter with enable.
// Synchronous active-low reset; o_last marks the final bit of a symbol.
module spc_phase_cnt
  import spc_pkg::*;
#(
  parameter int N  = SPC_OUT_W,
  parameter int PW = spc_phase_w(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [PW-1:0] o_phase,
  output logic          o_last
);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last  = (r_phase == PW'(N - 1));
  assign o_phase = r_phase;
  assign o_last  = w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= w_last ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/spc.sv
// spc: packs OUT_W consecutive serial bits into one symbol, first bit as MSB.
// Optional feature macro: SPC_VALID_EN (one-cycle dout_valid after update).
module spc
  import spc_pkg::*;
#(
  parameter int OUT_W = SPC_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
`ifdef SPC_VALID_EN
  output logic             dout_valid,
`endif
  output logic [OUT_W-1:0] dout
);

  localparam int PW = spc_phase_w(OUT_W);

  logic [PW-1:0]    w_phase;
  logic             w_last;
  logic             w_shift;
  logic [OUT_W-1:0] w_next;
  logic [OUT_W-2:0] r_sr;
  logic [OUT_W-1:0] r_dout;

  spc_phase_cnt #(
    .N  (OUT_W),
    .PW (PW)
  ) u_phase (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (en),
    .o_phase (w_phase),
    .o_last  (w_last)
  );

  // Partial bits plus the incoming one form the candidate symbol.
  assign w_next  = {r_sr, din};
  assign w_shift = en && (int'(w_phase) < OUT_W - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr   <= '0;
      r_dout <= '0;
    end else begin
      if (w_shift) begin
        r_sr <= w_next[OUT_W-2:0];
      end
      if (en && w_last) begin
        r_dout <= w_next;
      end
    end
  end

  assign dout = r_dout;

`ifdef SPC_VALID_EN
  logic r_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= en && w_last;
    end
  end

  assign dout_valid = r_valid;
`endif

endmodule

// File: tb/tb_spc.sv
// tb_spc: directed self-checking bench for spc.
// Build with SPC_VALID_EN defined to also check dout_valid.
module tb_spc;

  logic       clk;
  logic       reset;
  logic       en;
  logic       din;
  logic [1:0] dout;
`ifdef SPC_VALID_EN
  logic       dout_valid;
`endif

  int errors = 0;
  int checks = 0;

  spc dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   (din),
`ifdef SPC_VALID_EN
    .dout_valid (dout_valid),
`endif
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic d);
    @(negedge clk);
    reset = r;
    en    = e;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic exp);
`ifdef SPC_VALID_EN
    checks++;
    assert (dout_valid === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, dout_valid, exp);
    end
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  logic [7:0] pair_bits;
  logic [1:0] pair_exp [8];
  logic       prev;
  logic       b;
  logic [1:0] exp_dout;

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    din   = 1'b1;

    // Reset held two cycles with din high.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("reset_dout", dout, 2'd0);
    chkv("reset_valid", 1'b0);

    // Pairs: 1,0,0,1,1,1,0,0 -> 2,1,3,0 on even edges.
    pair_bits = 8'b10011100;
    pair_exp[0] = 2'd0; pair_exp[1] = 2'd2;
    pair_exp[2] = 2'd2; pair_exp[3] = 2'd1;
    pair_exp[4] = 2'd1; pair_exp[5] = 2'd3;
    pair_exp[6] = 2'd3; pair_exp[7] = 2'd0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, pair_bits[7-i]);
      chk($sformatf("pairs_e%0d", i + 1), dout, pair_exp[i]);
      chkv($sformatf("pairs_v%0d", i + 1), logic'(i % 2 == 1));
    end

    // Enable gating: 1, three idle cycles with toggling din, then 1.
    step(1'b1, 1'b1, 1'b1);
    chk("gate_first", dout, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, logic'(i % 2 == 0 ? 0 : 1));
      chk($sformatf("gate_idle%0d", i), dout, 2'd0);
      chkv($sformatf("gate_idle_v%0d", i), 1'b0);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("gate_done", dout, 2'd3);
    chkv("gate_done_v", 1'b1);

    // Reset mid-pair discards the pending bit.
    step(1'b1, 1'b1, 1'b1);
    chk("mid_first", dout, 2'd3);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_reset", dout, 2'd0);
    chkv("mid_reset_v", 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_b0", dout, 2'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_b1", dout, 2'd1);

    // Long random stream, checked on every edge against a pair model.
    exp_dout = 2'd1;
    prev     = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      b = logic'($urandom_range(0, 1));
      step(1'b1, 1'b1, b);
      if (i % 2 == 1) exp_dout = {prev, b};
      prev = b;
      chk($sformatf("long_%0d", i), dout, exp_dout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
